// File: rtl/fifo_protocol_checker_if.sv
// ============================================================================
// Module  : fifo_protocol_checker_if
// Brief   : Monitored sync-FIFO pointer/flag/enable bundle for the checker.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_protocol_checker_if #(
  parameter int PTR_WIDTH = 5
) ();
  logic                 wr_en;
  logic                 rd_en;
  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] rptr;
  logic                 full;
  logic                 empty;
  logic                 almostfull;
  logic                 almostempty;

  // master is the FIFO (or bench) producing the signals; slave is the checker.
  modport master (
    output wr_en, rd_en, wptr, rptr, full, empty, almostfull, almostempty
  );
  modport slave (
    input  wr_en, rd_en, wptr, rptr, full, empty, almostfull, almostempty
  );
endinterface

`default_nettype wire

// File: rtl/fifo_protocol_checker.sv
// ============================================================================
// Module  : fifo_protocol_checker
// Brief   : Sync-FIFO protocol checker with shadow occupancy, sticky errors,
//           saturating counters and first-error capture.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_protocol_checker #(
  parameter int PTR_WIDTH = 5,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  parameter int THR_MODE  = 1,
  parameter int CNT_WIDTH = 16
) (
  input  wire                  clk,
  input  wire                  rstn,
  fifo_protocol_checker_if.slave mon,
  input  wire                  clr_err,
  output logic [7:0]           err_vec,
  output logic                 err_any,
  output logic                 first_err_valid,
  output logic [2:0]           first_err_id,
  output logic [CNT_WIDTH-1:0] first_err_cycle,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic [CNT_WIDTH-1:0] wr_drop_cnt,
  output logic [CNT_WIDTH-1:0] rd_drop_cnt,
  output logic [PTR_WIDTH-1:0] shadow_occ
);

  localparam int                   DEPTH    = 2 ** (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] c_depth  = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] c_af_thr = PTR_WIDTH'(DEPTH - AF_MARGIN);
  localparam logic [PTR_WIDTH-1:0] c_ae_thr = PTR_WIDTH'(AE_MARGIN);
  localparam logic [PTR_WIDTH-1:0] c_one    = PTR_WIDTH'(1);
  localparam logic c_c0_af = (AF_MARGIN == 0) ? 1'b0 :
                             (THR_MODE != 0) ? ((DEPTH - AF_MARGIN) <= 0) : 1'b0;
  localparam logic c_c0_ae = (THR_MODE != 0) || (AE_MARGIN == 0);

  logic                 r_post_rst;
  logic                 r_prev_valid;
  logic [PTR_WIDTH-1:0] r_prev_wptr;
  logic [PTR_WIDTH-1:0] r_prev_rptr;
  logic                 r_prev_acc_w;
  logic                 r_prev_acc_r;
  logic [PTR_WIDTH-1:0] r_shadow;
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [7:0]           r_err_vec;
  logic                 r_err_any;
  logic                 r_first_valid;
  logic [2:0]           r_first_id;
  logic [CNT_WIDTH-1:0] r_first_cycle;
  logic [CNT_WIDTH-1:0] r_err_count;
  logic [CNT_WIDTH-1:0] r_wr_drop;
  logic [CNT_WIDTH-1:0] r_rd_drop;

  logic [PTR_WIDTH-1:0] w_occ;
  logic [PTR_WIDTH-1:0] w_occ_mod;
  logic [PTR_WIDTH-1:0] w_wptr_inc;
  logic [PTR_WIDTH-1:0] w_rptr_inc;
  logic                 w_acc_w;
  logic                 w_acc_r;
  logic                 w_live;
  logic                 w_af_exp;
  logic                 w_ae_exp;
  logic [7:0]           w_chk;
  logic                 w_fail;
  logic [2:0]           w_first_id;
  logic [7:0]           w_err_vec_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign w_occ      = mon.wptr - mon.rptr;
  assign w_occ_mod  = {1'b0, w_occ[PTR_WIDTH-2:0]};
  assign w_wptr_inc = r_prev_wptr + c_one;
  assign w_rptr_inc = r_prev_rptr + c_one;
  assign w_acc_w    = mon.wr_en && !mon.full;
  assign w_acc_r    = mon.rd_en && !mon.empty;
  assign w_live     = !r_post_rst && r_prev_valid;

  // Legacy mode only demands the flag at the exact margin point (one-way).
  assign w_af_exp = (THR_MODE != 0) ? (w_occ >= c_af_thr) :
                    (((AF_MARGIN != 0) && (w_occ_mod == c_af_thr)) ||
                     ((AF_MARGIN == 0) && mon.full));
  assign w_ae_exp = (THR_MODE != 0) ? (w_occ <= c_ae_thr) :
                    (((AE_MARGIN != 0) && (w_occ_mod == c_ae_thr)) ||
                     ((AE_MARGIN == 0) && mon.empty));

  always_comb begin
    w_chk    = '0;
    w_chk[0] = r_post_rst &&
               !((mon.wptr == '0) && (mon.rptr == '0) && mon.empty && !mon.full &&
                 (mon.almostfull == c_c0_af) && (mon.almostempty == c_c0_ae));
    w_chk[1] = w_live && (mon.wptr != (r_prev_acc_w ? w_wptr_inc : r_prev_wptr));
    w_chk[2] = w_live && (mon.rptr != (r_prev_acc_r ? w_rptr_inc : r_prev_rptr));
    w_chk[3] = !r_post_rst && (mon.full != (w_occ == c_depth));
    w_chk[4] = !r_post_rst && (mon.empty != (w_occ == '0));
    w_chk[5] = !r_post_rst && ((THR_MODE != 0) ? (mon.almostfull != w_af_exp)
                                              : (w_af_exp && !mon.almostfull));
    w_chk[6] = !r_post_rst && ((THR_MODE != 0) ? (mon.almostempty != w_ae_exp)
                                              : (w_ae_exp && !mon.almostempty));
    w_chk[7] = w_live && (r_shadow != w_occ);
  end

  always_comb begin
    w_first_id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_chk[i]) w_first_id = 3'(i);
    end
  end

  assign w_fail        = |w_chk;
  assign w_err_vec_nxt = clr_err ? w_chk : (r_err_vec | w_chk);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_post_rst    <= 1'b1;
      r_prev_valid  <= 1'b0;
      r_prev_wptr   <= '0;
      r_prev_rptr   <= '0;
      r_prev_acc_w  <= 1'b0;
      r_prev_acc_r  <= 1'b0;
      r_shadow      <= '0;
      r_cycle_cnt   <= '0;
      r_err_vec     <= '0;
      r_err_any     <= 1'b0;
      r_first_valid <= 1'b0;
      r_first_id    <= '0;
      r_first_cycle <= '0;
      r_err_count   <= '0;
      r_wr_drop     <= '0;
      r_rd_drop     <= '0;
    end else begin
      r_post_rst   <= 1'b0;
      r_prev_valid <= 1'b1;
      r_prev_wptr  <= mon.wptr;
      r_prev_rptr  <= mon.rptr;
      r_prev_acc_w <= w_acc_w;
      r_prev_acc_r <= w_acc_r;
      r_cycle_cnt  <= sat_inc(r_cycle_cnt);

      case ({w_acc_w, w_acc_r})
        2'b10:   r_shadow <= r_shadow + c_one;
        2'b01:   r_shadow <= r_shadow - c_one;
        default: r_shadow <= r_shadow;
      endcase

      if (mon.wr_en && mon.full)  r_wr_drop <= sat_inc(r_wr_drop);
      if (mon.rd_en && mon.empty) r_rd_drop <= sat_inc(r_rd_drop);

      r_err_vec <= w_err_vec_nxt;
      r_err_any <= |w_err_vec_nxt;

      // A failure on the clearing edge survives the clear.
      if (clr_err) begin
        r_err_count   <= w_fail ? CNT_WIDTH'(1) : '0;
        r_first_valid <= w_fail;
        r_first_id    <= w_fail ? w_first_id : '0;
        r_first_cycle <= w_fail ? r_cycle_cnt : '0;
      end else begin
        if (w_fail) r_err_count <= sat_inc(r_err_count);
        if (!r_first_valid && w_fail) begin
          r_first_valid <= 1'b1;
          r_first_id    <= w_first_id;
          r_first_cycle <= r_cycle_cnt;
        end
      end
    end
  end

  assign err_vec         = r_err_vec;
  assign err_any         = r_err_any;
  assign first_err_valid = r_first_valid;
  assign first_err_id    = r_first_id;
  assign first_err_cycle = r_first_cycle;
  assign err_count       = r_err_count;
  assign wr_drop_cnt     = r_wr_drop;
  assign rd_drop_cnt     = r_rd_drop;
  assign shadow_occ      = r_shadow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_protocol_checker.sv
// ============================================================================
// Module  : tb_fifo_protocol_checker
// Brief   : Bench driving the checker from a behavioural FIFO model, both modes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_protocol_checker;

  localparam int PW    = 5;
  localparam int DEPTH = 16;
  localparam int AF    = 2;
  localparam int AE    = 2;
  localparam int CW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic clr_err;

  fifo_protocol_checker_if #(.PTR_WIDTH(PW)) if1 ();
  fifo_protocol_checker_if #(.PTR_WIDTH(PW)) if0 ();

  logic [7:0]    v1, v0;
  logic          any1, any0, fv1, fv0;
  logic [2:0]    fid1, fid0;
  logic [CW-1:0] fcy1, fcy0, ec1, ec0, wd1, wd0, rd1, rd0;
  logic [PW-1:0] so1, so0;

  fifo_protocol_checker #(.PTR_WIDTH(PW), .AF_MARGIN(AF), .AE_MARGIN(AE),
                          .THR_MODE(1), .CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rstn(rstn), .mon(if1), .clr_err(clr_err),
    .err_vec(v1), .err_any(any1), .first_err_valid(fv1), .first_err_id(fid1),
    .first_err_cycle(fcy1), .err_count(ec1), .wr_drop_cnt(wd1), .rd_drop_cnt(rd1),
    .shadow_occ(so1));

  fifo_protocol_checker #(.PTR_WIDTH(PW), .AF_MARGIN(AF), .AE_MARGIN(AE),
                          .THR_MODE(0), .CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rstn(rstn), .mon(if0), .clr_err(clr_err),
    .err_vec(v0), .err_any(any0), .first_err_valid(fv0), .first_err_id(fid0),
    .first_err_cycle(fcy0), .err_count(ec0), .wr_drop_cnt(wd0), .rd_drop_cnt(rd0),
    .shadow_occ(so0));

  // Ideal FIFO: unbounded write/read counts; faults are applied to if1 only.
  int wp, rp, wdrop, rdrop, wofs;
  bit inv_empty, force_full;
  int checks   = 0;
  int failures = 0;

  task automatic drive(input bit wr, input bit rd);
    int occ;
    occ = wp - rp;
    if1.wr_en       = wr;
    if1.rd_en       = rd;
    if1.wptr        = PW'(wp + wofs);
    if1.rptr        = PW'(rp);
    if1.full        = (occ == DEPTH) || force_full;
    if1.empty       = (occ == 0) ^ inv_empty;
    if1.almostfull  = (occ >= DEPTH - AF);
    if1.almostempty = (occ <= AE);
    if0.wr_en       = wr;
    if0.rd_en       = rd;
    if0.wptr        = PW'(wp);
    if0.rptr        = PW'(rp);
    if0.full        = (occ == DEPTH);
    if0.empty       = (occ == 0);
    if0.almostfull  = ((occ % DEPTH) == DEPTH - AF);
    if0.almostempty = ((occ % DEPTH) == AE);
  endtask

  task automatic tick(input bit wr, input bit rd);
    int occ;
    drive(wr, rd);
    occ = wp - rp;
    @(posedge clk);
    if (wr && occ == DEPTH) wdrop++;
    if (rd && occ == 0)     rdrop++;
    if (wr && occ < DEPTH)  wp++;
    if (rd && occ > 0)      rp++;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rstn = 1'b0;
    clr_err = 1'b0;
    wp = 0; rp = 0; wdrop = 0; rdrop = 0; wofs = 0;
    inv_empty = 1'b0; force_full = 1'b0;
    drive(1'b0, 1'b0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clr_err = 1'b0;
    wp = 0; rp = 0; wdrop = 0; rdrop = 0; wofs = 0;
    inv_empty = 1'b0; force_full = 1'b0;
    drive(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (v1 !== 8'h00) begin failures++; $display("FAIL rst_errvec got=%h exp=00", v1); end
    checks++; if (so1 !== '0) begin failures++; $display("FAIL rst_shadow got=%0d exp=0", so1); end
    checks++; if (fv1 !== 1'b0) begin failures++; $display("FAIL rst_fvalid got=%b exp=0", fv1); end
    #1 rstn = 1'b1;
    repeat (10) tick(1'b0, 1'b0);
    checks++; if (v1 !== 8'h00) begin failures++; $display("FAIL idle_errvec1 got=%h exp=00", v1); end
    checks++; if (v0 !== 8'h00) begin failures++; $display("FAIL idle_errvec0 got=%h exp=00", v0); end
    checks++; if (so1 !== '0) begin failures++; $display("FAIL idle_shadow got=%0d exp=0", so1); end
    checks++; if (ec1 !== '0) begin failures++; $display("FAIL idle_errcnt got=%0d exp=0", ec1); end
  endtask

  task automatic test_c0();
    do_reset();
    force_full = 1'b1;
    tick(1'b0, 1'b0);
    force_full = 1'b0;
    tick(1'b0, 1'b0);
    checks++; if (v1 !== 8'h01) begin failures++; $display("FAIL c0_errvec got=%h exp=01", v1); end
    checks++; if (fid1 !== 3'd0) begin failures++; $display("FAIL c0_id got=%0d exp=0", fid1); end
    checks++; if (fcy1 !== '0) begin failures++; $display("FAIL c0_cycle got=%0d exp=0", fcy1); end
    checks++; if (v0 !== 8'h00) begin failures++; $display("FAIL c0_legacy got=%h exp=00", v0); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0);
      checks++; if (so1 !== PW'(wp - rp)) begin failures++; $display("FAIL fill_shadow got=%0d exp=%0d", so1, wp - rp); end
    end
    tick(1'b1, 1'b0);
    checks++; if (wd1 !== CW'(1)) begin failures++; $display("FAIL wdrop got=%0d exp=1", wd1); end
    checks++; if (so1 !== PW'(DEPTH)) begin failures++; $display("FAIL full_shadow got=%0d exp=%0d", so1, DEPTH); end
    checks++; if (v1 !== 8'h00) begin failures++; $display("FAIL full_errvec got=%h exp=00", v1); end
    tick(1'b1, 1'b1);
    checks++; if (so1 !== PW'(DEPTH - 1)) begin failures++; $display("FAIL fullrw_shadow got=%0d exp=%0d", so1, DEPTH - 1); end
    repeat (DEPTH) tick(1'b0, 1'b1);
    checks++; if (rd1 !== CW'(1)) begin failures++; $display("FAIL rdrop got=%0d exp=1", rd1); end
    checks++; if (v1 !== 8'h00 || v0 !== 8'h00) begin failures++; $display("FAIL drain_errvec got=%h/%h exp=00/00", v1, v0); end
  endtask

  task automatic test_empty_err();
    do_reset();
    repeat (5) tick(1'b0, 1'b0);
    inv_empty = 1'b1;
    tick(1'b0, 1'b0);
    inv_empty = 1'b0;
    checks++; if (v1 !== 8'h10) begin failures++; $display("FAIL emp_errvec got=%h exp=10", v1); end
    checks++; if (fid1 !== 3'd4) begin failures++; $display("FAIL emp_id got=%0d exp=4", fid1); end
    checks++; if (fcy1 !== CW'(5)) begin failures++; $display("FAIL emp_cycle got=%0d exp=5", fcy1); end
    repeat (3) tick(1'b0, 1'b0);
    checks++; if (v1 !== 8'h10) begin failures++; $display("FAIL emp_sticky got=%h exp=10", v1); end
    checks++; if (ec1 !== CW'(1)) begin failures++; $display("FAIL emp_errcnt got=%0d exp=1", ec1); end
    checks++; if (any1 !== 1'b1) begin failures++; $display("FAIL emp_any got=%b exp=1", any1); end
  endtask

  task automatic test_ptr_jump();
    do_reset();
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    wofs = 1;
    tick(1'b0, 1'b0);
    checks++; if (v1 !== 8'h82) begin failures++; $display("FAIL jump_errvec got=%h exp=82", v1); end
    checks++; if (fid1 !== 3'd1) begin failures++; $display("FAIL jump_id got=%0d exp=1", fid1); end
    checks++; if (fcy1 !== CW'(2)) begin failures++; $display("FAIL jump_cycle got=%0d exp=2", fcy1); end
    wofs = 0;
  endtask

  task automatic test_random();
    int pw;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      pw = (i % 100 < 40) ? 85 : (i % 100 < 70) ? 15 : 50;
      tick(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < 100 - pw));
      checks++; if (v1 !== 8'h00) begin failures++; $display("FAIL rnd_errvec1 i=%0d got=%h exp=00", i, v1); end
      checks++; if (v0 !== 8'h00) begin failures++; $display("FAIL rnd_errvec0 i=%0d got=%h exp=00", i, v0); end
      checks++; if (so1 !== PW'(wp - rp)) begin failures++; $display("FAIL rnd_shadow1 i=%0d got=%0d exp=%0d", i, so1, wp - rp); end
      checks++; if (so0 !== PW'(wp - rp)) begin failures++; $display("FAIL rnd_shadow0 i=%0d got=%0d exp=%0d", i, so0, wp - rp); end
    end
    checks++; if (wd1 !== CW'(wdrop)) begin failures++; $display("FAIL rnd_wdrop got=%0d exp=%0d", wd1, wdrop); end
    checks++; if (rd0 !== CW'(rdrop)) begin failures++; $display("FAIL rnd_rdrop got=%0d exp=%0d", rd0, rdrop); end
  endtask

  task automatic test_clr_and_reset();
    do_reset();
    inv_empty = 1'b1;
    tick(1'b0, 1'b0);
    inv_empty = 1'b0;
    tick(1'b0, 1'b0);
    clr_err = 1'b1;
    tick(1'b0, 1'b0);
    clr_err = 1'b0;
    checks++; if (v1 !== 8'h00) begin failures++; $display("FAIL clr_errvec got=%h exp=00", v1); end
    checks++; if (ec1 !== '0) begin failures++; $display("FAIL clr_errcnt got=%0d exp=0", ec1); end
    checks++; if (fv1 !== 1'b0 || any1 !== 1'b0) begin failures++; $display("FAIL clr_valid got=%b/%b exp=0/0", fv1, any1); end
    clr_err = 1'b1;
    inv_empty = 1'b1;
    tick(1'b0, 1'b0);
    clr_err = 1'b0;
    inv_empty = 1'b0;
    checks++; if (v1 !== 8'h10) begin failures++; $display("FAIL clrwin_errvec got=%h exp=10", v1); end
    checks++; if (fv1 !== 1'b1 || fid1 !== 3'd4) begin failures++; $display("FAIL clrwin_cap got=%b/%0d exp=1/4", fv1, fid1); end
    checks++; if (fcy1 !== CW'(3)) begin failures++; $display("FAIL clrwin_cycle got=%0d exp=3", fcy1); end
    checks++; if (ec1 !== CW'(1)) begin failures++; $display("FAIL clrwin_cnt got=%0d exp=1", ec1); end
    repeat (3) tick(1'b1, 1'b0);
    checks++; if (so1 !== PW'(3)) begin failures++; $display("FAIL pre_rst_shadow got=%0d exp=3", so1); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (v1 !== 8'h00 || any1 !== 1'b0) begin failures++; $display("FAIL async_errvec got=%h/%b exp=00/0", v1, any1); end
    checks++; if (so1 !== '0) begin failures++; $display("FAIL async_shadow got=%0d exp=0", so1); end
    checks++; if (fv1 !== 1'b0 || ec1 !== '0 || fcy1 !== '0) begin failures++; $display("FAIL async_capture got=%b/%0d/%0d exp=0/0/0", fv1, ec1, fcy1); end
    wp = 0; rp = 0; wofs = 0;
    drive(1'b0, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (4) tick(1'b0, 1'b0);
    checks++; if (v1 !== 8'h00) begin failures++; $display("FAIL rearm_errvec got=%h exp=00", v1); end
  endtask

  initial begin
    test_reset();
    test_c0();
    test_fill_drain();
    test_empty_err();
    test_ptr_jump();
    test_random();
    test_clr_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
